// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// default operand width and a plain-arithmetic multiply reference.
package mul_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } mul_state_t;

  // Reference product for benches; operands up to 16 bits.
  function automatic logic [31:0] mul_ref(input logic [15:0] x, input logic [15:0] y);
    return 32'(x) * 32'(y);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: conditionally adds the multiplicand, shifts both
// operands and flags the final step (count exhausted or multiplier drained).
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH) + 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [CW-1:0]      cnt,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [2*WIDTH-1:0] mcand_nx,
  output logic [WIDTH-1:0]   mplier_nx,
  output logic               last
);

  // Partial-product accumulate and operand shift for one multiplier bit.
  always_comb begin
    acc_nx    = acc;
    mcand_nx  = mcand << 1;
    mplier_nx = mplier >> 1;
    if (mplier[0]) begin
      acc_nx = acc + mcand;
    end else begin
      acc_nx = acc;
    end
    last = (cnt == CW'(WIDTH - 1)) ||
           ((EARLY_EXIT != 0) && (mplier_nx == {WIDTH{1'b0}}));
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier P = A * B, one partial product per clock,
// valid/ready handshakes on both sides with a single operation in flight.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EARLY_EXIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t           state_r;
  mul_state_t           state_nx_s;
  logic [2*WIDTH-1:0]   acc_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   p_r;

  logic [2*WIDTH-1:0]   acc_nx_s;
  logic [2*WIDTH-1:0]   mcand_nx_s;
  logic [WIDTH-1:0]     mplier_nx_s;
  logic                 last_s;

  mul_step #(
    .WIDTH      (WIDTH),
    .EARLY_EXIT (EARLY_EXIT),
    .CW         (CW)
  ) u_step (
    .acc       (acc_r),
    .mcand     (mcand_r),
    .mplier    (mplier_r),
    .cnt       (cnt_r),
    .acc_nx    (acc_nx_s),
    .mcand_nx  (mcand_nx_s),
    .mplier_nx (mplier_nx_s),
    .last      (last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; in IDLE the block is always ready, so in_valid alone accepts.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx_s = RUN;
        else          state_nx_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nx_s = IDLE;
        else           state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and product latch on the final step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      p_r      <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, a};
            mplier_r <= b;
            cnt_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          acc_r    <= acc_nx_s;
          mcand_r  <= mcand_nx_s;
          mplier_r <= mplier_nx_s;
          cnt_r    <= cnt_r + CW'(1);
          if (last_s) p_r <= acc_nx_s;
        end
        DONE: begin
          p_r <= p_r;
        end
        default: begin
          acc_r <= {(2*WIDTH){1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r == RUN) || (state_r == DONE);
  assign p         = p_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: two multipliers (EARLY_EXIT 0 and 1) driven one at a
// time through directed and random operations against arithmetic expectations.
module tb_seq_multiplier;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  av = 8'd0;
  logic [7:0]  bv = 8'd0;
  logic        iv  [0:1];
  logic        orr [0:1];
  logic        ir  [0:1];
  logic        ovl [0:1];
  logic [15:0] pl  [0:1];
  logic        by  [0:1];

  int total = 0;
  int bad   = 0;
  int sel   = 0;
  int n_acc = 0;
  int n_prod = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(0)) dut_e0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av), .b(bv),
    .out_valid(ovl[0]), .out_ready(orr[0]), .p(pl[0]), .busy(by[0]));

  seq_multiplier #(.WIDTH(8), .EARLY_EXIT(1)) dut_e1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av), .b(bv),
    .out_valid(ovl[1]), .out_ready(orr[1]), .p(pl[1]), .busy(by[1]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the accept edge (counted as 1) to the edge raising out_valid.
  function automatic int exp_lat(input int ee, input logic [7:0] bb);
    int h;
    h = 0;
    if (ee == 0) return 9;
    for (int i = 0; i < 8; i++) if (bb[i]) h = i;
    return h + 2;
  endfunction

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input int stall,
                       input bit chk_lat);
    int n;
    int lat;
    logic [15:0] expp;
    expp = 16'(x * y);
    av = x; bv = y;
    orr[sel] = 1'b1;
    iv[sel] = 1'b1;
    n = 0;
    while (!ir[sel] && n < 50) begin tick(); n++; end
    chk("in_ready_before_accept", 32'(ir[sel]), 32'd1);
    tick();
    iv[sel] = 1'b0;
    n_acc++;
    lat = 1;
    while (!ovl[sel] && lat < 50) begin tick(); lat++; end
    chk("out_valid_seen", 32'(ovl[sel]), 32'd1);
    if (chk_lat) chk("latency", 32'(lat), 32'(exp_lat(sel, y)));
    chk("product", 32'(pl[sel]), 32'(expp));
    n_prod++;
    if (stall > 0) begin
      orr[sel] = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        chk("stall_p_held", 32'(pl[sel]), 32'(expp));
        chk("stall_out_valid", 32'(ovl[sel]), 32'd1);
      end
      orr[sel] = 1'b1;
    end
    tick();
    chk("after_out_valid", 32'(ovl[sel]), 32'd0);
    chk("after_in_ready", 32'(ir[sel]), 32'd1);
  endtask

  logic [7:0]  pa [0:3];
  logic [7:0]  pb [0:3];
  logic [15:0] held;
  logic [7:0]  ra;
  logic [7:0]  rb;

  initial begin
    int n;
    iv[0] = 1'b0; iv[1] = 1'b0;
    orr[0] = 1'b1; orr[1] = 1'b1;
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      chk("reset_in_ready", 32'(ir[s]), 32'd1);
      chk("reset_out_valid", 32'(ovl[s]), 32'd0);
      chk("reset_busy", 32'(by[s]), 32'd0);
      chk("reset_p", 32'(pl[s]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Reset in the middle of a run, then a fresh operation.
    sel = 0;
    av = 8'd200; bv = 8'd255; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick(); tick(); tick();
    chk("midrun_busy", 32'(by[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(ovl[0]), 32'd0);
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    chk("midrst_p", 32'(pl[0]), 32'd0);
    chk("midrst_busy", 32'(by[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_op(8'd3, 8'd4, 0, 1'b1);

    // Basic and corner operands on both variants.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      do_op(8'd13, 8'd11, 0, 1'b1);
      do_op(8'd0, 8'd200, 0, 1'b1);
      do_op(8'd200, 8'd0, 0, 1'b1);
      do_op(8'd1, 8'd255, 0, 1'b1);
      do_op(8'd255, 8'd255, 0, 1'b1);
      do_op(8'd77, 8'd1, 0, 1'b1);
      do_op(8'd9, 8'd128, 0, 1'b1);
    end

    // Backpressure: product held, operands offered meanwhile are ignored.
    sel = 1;
    av = 8'd100; bv = 8'd37; iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    n = 0;
    while (!ovl[1] && n < 50) begin tick(); n++; end
    chk("bp_out_valid", 32'(ovl[1]), 32'd1);
    chk("bp_product", 32'(pl[1]), 32'd3700);
    held = pl[1];
    orr[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = 8'($urandom_range(1, 255));
      iv[1] = i[0];
      tick();
      chk("bp_p_stable", 32'(pl[1]), 32'(held));
      chk("bp_in_ready", 32'(ir[1]), 32'd0);
      chk("bp_out_valid_hold", 32'(ovl[1]), 32'd1);
    end
    iv[1] = 1'b0;
    orr[1] = 1'b1;
    tick();
    chk("bp_release_out_valid", 32'(ovl[1]), 32'd0);
    chk("bp_release_in_ready", 32'(ir[1]), 32'd1);
    tick(); tick();
    chk("bp_no_extra_op", 32'(by[1]), 32'd0);

    // Back-to-back with in_valid held; operands change while running.
    sel = 0;
    pa[0] = 8'd17;  pb[0] = 8'd23;
    pa[1] = 8'd250; pb[1] = 8'd3;
    pa[2] = 8'd64;  pb[2] = 8'd64;
    pa[3] = 8'd5;   pb[3] = 8'd201;
    av = pa[0]; bv = pb[0];
    iv[0] = 1'b1; orr[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!ir[0] && n < 50) begin tick(); n++; end
      chk("b2b_ready", 32'(ir[0]), 32'd1);
      tick();
      if (i < 3) begin av = pa[i+1]; bv = pb[i+1]; end
      n = 0;
      while (!ovl[0] && n < 50) begin tick(); n++; end
      chk("b2b_out_valid", 32'(ovl[0]), 32'd1);
      chk("b2b_product", 32'(pl[0]), mul_ref(16'(pa[i]), 16'(pb[i])));
      if (i == 3) iv[0] = 1'b0;
      tick();
    end
    tick();
    chk("b2b_idle", 32'(by[0]), 32'd0);

    // Random operands with random stalls on both variants.
    n_acc = 0; n_prod = 0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int k = 0; k < 1500; k++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) rb = 8'($urandom_range(0, 3));
        repeat ($urandom_range(0, 2)) tick();
        do_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, 1'b1);
      end
    end
    chk("accepts_eq_products", 32'(n_acc), 32'(n_prod));
    chk("accepts_total", 32'(n_acc), 32'd3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
